// File: rtl/matvec_sequencer_if.sv
// Command word stream from the SPI bridge plus the operand-memory write port.
interface matvec_sequencer_if #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 10
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [15:0]          cmd_data;
  logic                 w_en;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [WORD_SIZE-1:0] w_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready,
                  input w_en, input w_addr, input w_data);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready,
                  output w_en, output w_addr, output w_data);
endinterface

// File: rtl/matvec_sequencer.sv
// Command-driven controller: loads vector/matrix into operand memory, sequences
// the systolic array through compute and readout, and writes results back.
module matvec_sequencer #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter int unsigned          ADDR_SIZE = 10,
  parameter int unsigned          PE_NUMBER = 64,
  parameter int unsigned          DIM_W     = 8,
  parameter logic [ADDR_SIZE-1:0] VEC_BASE  = 10'h00f,
  parameter logic [ADDR_SIZE-1:0] MAT_BASE  = 10'h04f,
  parameter logic [ADDR_SIZE-1:0] RES_BASE  = 10'h3c0,
  parameter logic [ADDR_SIZE-1:0] ZERO_ADDR = 10'h3ff
) (
  input  logic                           clk,
  input  logic                           reset,
  matvec_sequencer_if.slave              bus,
  output logic [ADDR_SIZE-1:0]           l_d_o_addr,
  output logic [PE_NUMBER*ADDR_SIZE-1:0] pe_t_o_addr,
  output logic                           array_clear,
  output logic                           array_read,
  input  logic [WORD_SIZE-1:0]           arr_result,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);
  localparam int unsigned KW = 2 * DIM_W;
  localparam int unsigned TW = DIM_W + 1;
  localparam int unsigned PW = 2 * DIM_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD_VEC, LOAD_MAT, COMPUTE, READ} state_t;

  state_t                                state, state_nxt;
  logic [DIM_W-1:0]                      n, n_nxt, m, m_nxt, j, j_nxt;
  logic [KW-1:0]                         k, k_nxt;
  logic [TW-1:0]                         t, t_nxt;
  logic                                  err_nxt, ready_nxt, w_en_nxt, done_nxt;
  logic                                  busy_nxt, clear_nxt, read_nxt;
  logic [ADDR_SIZE-1:0]                  w_addr_nxt, l_addr_nxt, row_base;
  logic [WORD_SIZE-1:0]                  w_data_nxt;
  logic [PE_NUMBER-1:0][ADDR_SIZE-1:0]   pe_addr, pe_addr_nxt;
  logic                                  accept, dim_ok, comp_nxt;
  logic [3:0]                            opcode;
  logic [DIM_W-1:0]                      dim;
  logic [KW-1:0]                         total;
  logic [TW-1:0]                         last_t;

  assign accept      = bus.cmd_valid && bus.cmd_ready;
  assign opcode      = bus.cmd_data[15:12];
  assign dim         = bus.cmd_data[DIM_W-1:0];
  assign dim_ok      = (dim != '0) && (32'(dim) <= PE_NUMBER);
  assign total       = KW'(n) * KW'(m);
  assign last_t      = TW'(n) + TW'(m) - TW'(2);
  assign pe_t_o_addr = pe_addr;

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_nxt  = state;
    n_nxt      = n;
    m_nxt      = m;
    k_nxt      = k;
    t_nxt      = t;
    j_nxt      = j;
    err_nxt    = err;
    w_en_nxt   = 1'b0;
    w_addr_nxt = bus.w_addr;
    w_data_nxt = bus.w_data;
    done_nxt   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        case (opcode)
          4'h1: if (dim_ok) n_nxt = dim; else err_nxt = 1'b1;
          4'h2: if (dim_ok) m_nxt = dim; else err_nxt = 1'b1;
          4'h4: if (n == '0) err_nxt = 1'b1;
                else begin state_nxt = LOAD_VEC; k_nxt = '0; end
          4'h5: if (n == '0 || m == '0) err_nxt = 1'b1;
                else begin state_nxt = LOAD_MAT; k_nxt = '0; end
          4'h3: if (n == '0 || m == '0) err_nxt = 1'b1;
                else begin state_nxt = COMPUTE; t_nxt = '0; end
          4'hf: err_nxt = 1'b0;
          default: err_nxt = 1'b1;
        endcase
      end
      LOAD_VEC: if (accept) begin
        w_en_nxt   = 1'b1;
        w_addr_nxt = VEC_BASE + ADDR_SIZE'(k);
        w_data_nxt = WORD_SIZE'(bus.cmd_data);
        k_nxt      = k + KW'(1);
        if (k == KW'(n) - KW'(1)) state_nxt = IDLE;
      end
      LOAD_MAT: if (accept) begin
        w_en_nxt   = 1'b1;
        w_addr_nxt = MAT_BASE + ADDR_SIZE'(k);
        w_data_nxt = WORD_SIZE'(bus.cmd_data);
        k_nxt      = k + KW'(1);
        if (k == total - KW'(1)) state_nxt = IDLE;
      end
      COMPUTE: begin
        if (t == last_t) begin
          state_nxt = READ;
          j_nxt     = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      READ: begin
        // Result sampled this cycle lands in memory next cycle.
        w_en_nxt   = 1'b1;
        w_addr_nxt = RES_BASE + ADDR_SIZE'(j);
        w_data_nxt = arr_result;
        if (j == m - DIM_W'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          j_nxt = j + DIM_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt  = (state_nxt == IDLE) || (state_nxt == LOAD_VEC) || (state_nxt == LOAD_MAT);
    busy_nxt   = (state_nxt == COMPUTE) || (state_nxt == READ);
    clear_nxt  = !busy_nxt;
    read_nxt   = (state_nxt == READ);
    comp_nxt   = (state_nxt == COMPUTE);
    l_addr_nxt = (comp_nxt && t_nxt < TW'(n)) ? VEC_BASE + ADDR_SIZE'(t_nxt) : ZERO_ADDR;
    row_base   = MAT_BASE + ADDR_SIZE'(PW'(t_nxt) * PW'(n));
    for (int unsigned i = 0; i < PE_NUMBER; i++) begin
      pe_addr_nxt[i] = (comp_nxt && i < 32'(n) && t_nxt < TW'(m))
                       ? row_base + ADDR_SIZE'(i) : ZERO_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      n           <= '0;
      m           <= '0;
      k           <= '0;
      t           <= '0;
      j           <= '0;
      err         <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.w_en    <= 1'b0;
      bus.w_addr  <= '0;
      bus.w_data  <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      array_clear <= 1'b1;
      array_read  <= 1'b0;
      l_d_o_addr  <= ZERO_ADDR;
      pe_addr     <= {PE_NUMBER{ZERO_ADDR}};
    end else begin
      state       <= state_nxt;
      n           <= n_nxt;
      m           <= m_nxt;
      k           <= k_nxt;
      t           <= t_nxt;
      j           <= j_nxt;
      err         <= err_nxt;
      bus.cmd_ready <= ready_nxt;
      bus.w_en    <= w_en_nxt;
      bus.w_addr  <= w_addr_nxt;
      bus.w_data  <= w_data_nxt;
      done        <= done_nxt;
      busy        <= busy_nxt;
      array_clear <= clear_nxt;
      array_read  <= read_nxt;
      l_d_o_addr  <= l_addr_nxt;
      pe_addr     <= pe_addr_nxt;
    end
  end
endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer: vector table for loads/errors, hand
// sequences for compute/readout and mid-readout reset.
module tb_matvec_sequencer;
  localparam int unsigned AW = 10;
  localparam int unsigned WW = 16;
  localparam int unsigned PE = 64;
  localparam logic [AW-1:0] ZERO = 10'h3ff;

  logic clk, reset;
  logic [AW-1:0]    l_d_o_addr;
  logic [PE*AW-1:0] pe_t_o_addr;
  logic             array_clear, array_read, busy, done, err;
  logic [WW-1:0]    arr_result;

  matvec_sequencer_if #(.WORD_SIZE(WW), .ADDR_SIZE(AW)) bus ();

  matvec_sequencer dut (
    .clk(clk), .reset(reset), .bus(bus),
    .l_d_o_addr(l_d_o_addr), .pe_t_o_addr(pe_t_o_addr),
    .array_clear(array_clear), .array_read(array_read),
    .arr_result(arr_result), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        ready;
    logic        wen;
    logic [9:0]  waddr;
    logic [15:0] wdata;
    logic        err;
  } vec_t;

  vec_t tv[22];

  function automatic vec_t mk(logic v, logic [15:0] d, logic r, logic we,
                              logic [9:0] wa, logic [15:0] wd, logic e);
    vec_t x;
    x.valid = v; x.data = d; x.ready = r; x.wen = we;
    x.waddr = wa; x.wdata = wd; x.err = e;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    arr_result = '0;

    tv[0]  = mk(1, 16'h1002, 1, 0, 0, 0, 0);
    tv[1]  = mk(1, 16'h2003, 1, 0, 0, 0, 0);
    tv[2]  = mk(1, 16'h4000, 1, 0, 0, 0, 0);
    tv[3]  = mk(1, 16'h0005, 1, 1, 10'h00f, 16'h0005, 0);
    tv[4]  = mk(0, 16'h0000, 1, 0, 0, 0, 0);
    tv[5]  = mk(0, 16'h0000, 1, 0, 0, 0, 0);
    tv[6]  = mk(0, 16'h0000, 1, 0, 0, 0, 0);
    tv[7]  = mk(1, 16'h0007, 1, 1, 10'h010, 16'h0007, 0);
    tv[8]  = mk(1, 16'h1041, 1, 0, 0, 0, 1);
    tv[9]  = mk(1, 16'hf000, 1, 0, 0, 0, 0);
    tv[10] = mk(1, 16'h7000, 1, 0, 0, 0, 1);
    tv[11] = mk(1, 16'hf000, 1, 0, 0, 0, 0);
    tv[12] = mk(1, 16'h2000, 1, 0, 0, 0, 1);
    tv[13] = mk(1, 16'hf000, 1, 0, 0, 0, 0);
    tv[14] = mk(1, 16'h5000, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      tv[15+i] = mk(1, 16'(i + 1), 1, 1, 10'(10'h04f + i), 16'(i + 1), 0);
    tv[21] = mk(0, 16'h0000, 1, 0, 0, 0, 0);

    // Reset values
    repeat (3) step();
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_wen", bus.w_en, 0);
    chk("rst_clear", array_clear, 1);
    chk("rst_read", array_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_laddr", l_d_o_addr, ZERO);
    chk("rst_lanes", pe_t_o_addr === {PE{ZERO}}, 1);
    reset = 1'b0;
    step();
    chk("ready_after_rst", bus.cmd_ready, 1);

    // Vector table: configuration, loads with stall, error cases
    for (int i = 0; i < 22; i++) begin
      bus.cmd_valid = tv[i].valid;
      bus.cmd_data  = tv[i].data;
      step();
      chk($sformatf("v%0d_ready", i), bus.cmd_ready, tv[i].ready);
      chk($sformatf("v%0d_wen", i), bus.w_en, tv[i].wen);
      chk($sformatf("v%0d_err", i), err, tv[i].err);
      if (tv[i].wen) begin
        chk($sformatf("v%0d_waddr", i), bus.w_addr, tv[i].waddr);
        chk($sformatf("v%0d_wdata", i), bus.w_data, tv[i].wdata);
      end
    end

    // START_CAL with N=2, M=3: four compute cycles
    begin
      logic [9:0] exp_l[4], exp_p0[4], exp_p1[4];
      exp_l  = '{10'h00f, 10'h010, 10'h3ff, 10'h3ff};
      exp_p0 = '{10'h04f, 10'h051, 10'h053, 10'h3ff};
      exp_p1 = '{10'h050, 10'h052, 10'h054, 10'h3ff};
      send(16'h3000);
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("c%0d_ready", c), bus.cmd_ready, 0);
        chk($sformatf("c%0d_busy", c), busy, 1);
        chk($sformatf("c%0d_clear", c), array_clear, 0);
        chk($sformatf("c%0d_read", c), array_read, 0);
        chk($sformatf("c%0d_laddr", c), l_d_o_addr, exp_l[c]);
        chk($sformatf("c%0d_lane0", c), pe_t_o_addr[0 +: AW], exp_p0[c]);
        chk($sformatf("c%0d_lane1", c), pe_t_o_addr[AW +: AW], exp_p1[c]);
        chk($sformatf("c%0d_lanes_hi", c),
            pe_t_o_addr[PE*AW-1:2*AW] === {(PE-2){ZERO}}, 1);
        step();
      end
    end

    // READ: three results written to RES_BASE..+2, done with the last
    for (int jj = 0; jj < 3; jj++) begin
      chk($sformatf("r%0d_read", jj), array_read, 1);
      chk($sformatf("r%0d_ready", jj), bus.cmd_ready, 0);
      chk($sformatf("r%0d_laddr", jj), l_d_o_addr, ZERO);
      chk($sformatf("r%0d_lane0", jj), pe_t_o_addr[0 +: AW], ZERO);
      arr_result = 16'(16'h000a + jj);
      step();
      chk($sformatf("r%0d_wen", jj), bus.w_en, 1);
      chk($sformatf("r%0d_waddr", jj), bus.w_addr, 10'(10'h3c0 + jj));
      chk($sformatf("r%0d_wdata", jj), bus.w_data, 16'(16'h000a + jj));
      chk($sformatf("r%0d_done", jj), done, (jj == 2) ? 1 : 0);
    end
    chk("end_busy", busy, 0);
    chk("end_clear", array_clear, 1);
    chk("end_ready", bus.cmd_ready, 1);
    chk("end_read", array_read, 0);
    step();
    chk("post_done", done, 0);
    chk("post_wen", bus.w_en, 0);

    // Reset asserted in the second READ cycle
    send(16'h3000);
    repeat (4) step();
    arr_result = 16'h0011;
    step();
    chk("rr_read", array_read, 1);
    chk("rr_wen", bus.w_en, 1);
    reset = 1'b1;
    step();
    chk("rr_wen_off", bus.w_en, 0);
    chk("rr_read_off", array_read, 0);
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_clear", array_clear, 1);
    reset = 1'b0;
    step();
    chk("rr_wen_idle", bus.w_en, 0);
    chk("rr_ready", bus.cmd_ready, 1);

    // After reset N=M=0: START_CAL and WRITE_VEC are rejected
    send(16'h3000);
    chk("z_cal_err", err, 1);
    chk("z_cal_busy", busy, 0);
    chk("z_cal_ready", bus.cmd_ready, 1);
    send(16'hf000);
    chk("z_clr", err, 0);
    send(16'h4000);
    chk("z_vec_err", err, 1);
    step();
    chk("z_vec_wen", bus.w_en, 0);
    chk("done_pulses", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
